// File: rtl/alu_pkg.sv
// Shared definitions for the multi-cycle ALU: op encodings, FSM states, flag layout.
package alu_pkg;

   localparam int unsigned OP_W = 3;

   localparam logic [OP_W-1:0] OP_ADD = 3'b000;
   localparam logic [OP_W-1:0] OP_SUB = 3'b001;
   localparam logic [OP_W-1:0] OP_AND = 3'b010;
   localparam logic [OP_W-1:0] OP_OR  = 3'b011;
   localparam logic [OP_W-1:0] OP_XOR = 3'b100;
   localparam logic [OP_W-1:0] OP_SLT = 3'b101;
   localparam logic [OP_W-1:0] OP_SLL = 3'b110;
   localparam logic [OP_W-1:0] OP_MUL = 3'b111;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      MUL  = 2'd1,
      DONE = 2'd2
   } state_e;

   localparam int unsigned FLAG_ZERO  = 0;
   localparam int unsigned FLAG_CARRY = 1;
   localparam int unsigned FLAG_OVF   = 2;
   localparam int unsigned FLAG_NEG   = 3;
   localparam int unsigned NUM_FLAGS  = 4;

   // Packs individual flag bits into the flag register layout.
   function automatic logic [NUM_FLAGS-1:0] make_flags(input logic zero, input logic carry,
                                                       input logic ovf, input logic neg);
      logic [NUM_FLAGS-1:0] f;
      f             = '0;
      f[FLAG_ZERO]  = zero;
      f[FLAG_CARRY] = carry;
      f[FLAG_OVF]   = ovf;
      f[FLAG_NEG]   = neg;
      return f;
   endfunction

endpackage

// File: rtl/alu_shift_add_mul.sv
// Iterative unsigned shift-add multiplier: one multiplier bit per clock, 2*WIDTH product.
module alu_shift_add_mul #(
   parameter int unsigned WIDTH = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic [WIDTH-1:0]     a,
   input  logic [WIDTH-1:0]     b,
   output logic                 done_c,
   output logic [2*WIDTH-1:0]   product_c
);

   localparam int unsigned PW    = 2 * WIDTH;
   localparam int unsigned CNT_W = $clog2(WIDTH);

   logic [PW-1:0]    mcand_q, mcand_d;
   logic [PW-1:0]    acc_q, acc_d;
   logic [WIDTH-1:0] mplier_q, mplier_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             run_q, run_d;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mcand_q  <= '0;
         acc_q    <= '0;
         mplier_q <= '0;
         cnt_q    <= '0;
         run_q    <= 1'b0;
      end else begin
         mcand_q  <= mcand_d;
         acc_q    <= acc_d;
         mplier_q <= mplier_d;
         cnt_q    <= cnt_d;
         run_q    <= run_d;
      end
   end

   // Start loads operands; each running cycle consumes the multiplier LSB.
   always_comb begin
      mcand_d  = mcand_q;
      acc_d    = acc_q;
      mplier_d = mplier_q;
      cnt_d    = cnt_q;
      run_d    = run_q;
      if (start) begin
         mcand_d  = PW'(a);
         acc_d    = '0;
         mplier_d = b;
         cnt_d    = '0;
         run_d    = 1'b1;
      end else if (run_q) begin
         acc_d    = acc_q + (mplier_q[0] ? mcand_q : '0);
         mcand_d  = mcand_q << 1;
         mplier_d = mplier_q >> 1;
         cnt_d    = cnt_q + CNT_W'(1);
         if (cnt_q == CNT_W'(WIDTH - 1)) begin
            run_d = 1'b0;
         end
      end
   end

   // Final product is exposed combinationally so the caller can register it on the last iteration edge.
   assign done_c    = run_q && (cnt_q == CNT_W'(WIDTH - 1));
   assign product_c = acc_d;

endmodule

// File: rtl/alu_multicycle.sv
// Multi-cycle ALU with valid/ready handshakes: single-cycle ops plus an iterative MUL,
// registered answer and zero/carry/overflow/negative flags.
module alu_multicycle
   import alu_pkg::*;
#(
   parameter int unsigned WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] input1,
   input  logic [WIDTH-1:0] input2,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] answer,
   output logic             zerosignal,
   output logic             carry,
   output logic             overflow,
   output logic             negative,
   output logic             busy
);

   localparam int unsigned SH_W = $clog2(WIDTH);
   localparam int unsigned MSB  = WIDTH - 1;

   state_e               state_q, state_d;
   logic [WIDTH-1:0]     answer_q, answer_d;
   logic [NUM_FLAGS-1:0] flags_q, flags_d;
   logic                 out_valid_q, out_valid_d;
   logic                 in_ready_q, in_ready_d;
   logic                 busy_q, busy_d;

   logic                 accept_c;
   logic                 mul_start_c;
   logic                 mul_done_c;
   logic [2*WIDTH-1:0]   mul_product_c;
   logic [WIDTH:0]       sum_c, diff_c;
   logic [WIDTH-1:0]     alu_res_c;
   logic                 alu_carry_c, alu_ovf_c;

   assign accept_c    = in_valid && in_ready_q;
   assign mul_start_c = accept_c && (op == OP_MUL);

   alu_shift_add_mul #(.WIDTH(WIDTH)) u_mul (
      .clk       (clk),
      .rst       (rst),
      .start     (mul_start_c),
      .a         (input1),
      .b         (input2),
      .done_c    (mul_done_c),
      .product_c (mul_product_c)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (accept_c) state_d = (op == OP_MUL) ? MUL : DONE;
         MUL:     if (mul_done_c) state_d = DONE;
         DONE:    if (out_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Single-cycle datapath; carry of SUB is the no-borrow bit of the widened difference.
   always_comb begin
      sum_c       = {1'b0, input1} + {1'b0, input2};
      diff_c      = {1'b0, input1} - {1'b0, input2};
      alu_res_c   = '0;
      alu_carry_c = 1'b0;
      alu_ovf_c   = 1'b0;
      case (op)
         OP_ADD: begin
            alu_res_c   = sum_c[WIDTH-1:0];
            alu_carry_c = sum_c[WIDTH];
            alu_ovf_c   = (input1[MSB] == input2[MSB]) && (sum_c[MSB] != input1[MSB]);
         end
         OP_SUB: begin
            alu_res_c   = diff_c[WIDTH-1:0];
            alu_carry_c = ~diff_c[WIDTH];
            alu_ovf_c   = (input1[MSB] != input2[MSB]) && (diff_c[MSB] != input1[MSB]);
         end
         OP_AND:  alu_res_c = input1 & input2;
         OP_OR:   alu_res_c = input1 | input2;
         OP_XOR:  alu_res_c = input1 ^ input2;
         OP_SLT:  alu_res_c = WIDTH'($signed(input1) < $signed(input2));
         OP_SLL:  alu_res_c = input1 << input2[SH_W-1:0];
         default: alu_res_c = '0;
      endcase
   end

   always_comb begin
      answer_d    = answer_q;
      flags_d     = flags_q;
      out_valid_d = out_valid_q;
      case (state_q)
         IDLE: begin
            if (accept_c && (op != OP_MUL)) begin
               answer_d    = alu_res_c;
               flags_d     = make_flags(alu_res_c == '0, alu_carry_c, alu_ovf_c, alu_res_c[MSB]);
               out_valid_d = 1'b1;
            end
         end
         MUL: begin
            if (mul_done_c) begin
               answer_d    = mul_product_c[WIDTH-1:0];
               flags_d     = make_flags(mul_product_c[WIDTH-1:0] == '0, 1'b0,
                                        |mul_product_c[2*WIDTH-1:WIDTH], mul_product_c[MSB]);
               out_valid_d = 1'b1;
            end
         end
         DONE: begin
            if (out_ready) out_valid_d = 1'b0;
         end
         default: out_valid_d = 1'b0;
      endcase
      in_ready_d = (state_d == IDLE);
      busy_d     = (state_d != IDLE);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         answer_q    <= '0;
         flags_q     <= '0;
         out_valid_q <= 1'b0;
         in_ready_q  <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         answer_q    <= answer_d;
         flags_q     <= flags_d;
         out_valid_q <= out_valid_d;
         in_ready_q  <= in_ready_d;
         busy_q      <= busy_d;
      end
   end

   assign in_ready   = in_ready_q;
   assign out_valid  = out_valid_q;
   assign answer     = answer_q;
   assign zerosignal = flags_q[FLAG_ZERO];
   assign carry      = flags_q[FLAG_CARRY];
   assign overflow   = flags_q[FLAG_OVF];
   assign negative   = flags_q[FLAG_NEG];
   assign busy       = busy_q;

endmodule

// File: tb/tb_alu_multicycle.sv
// Scoreboard bench for alu_multicycle (WIDTH=16): expected results queued at issue, popped at out_valid.
module tb_alu_multicycle;

   localparam logic [2:0] T_ADD = 3'd0, T_SUB = 3'd1, T_AND = 3'd2, T_OR  = 3'd3;
   localparam logic [2:0] T_XOR = 3'd4, T_SLT = 3'd5, T_SLL = 3'd6, T_MUL = 3'd7;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid, in_ready, out_valid, out_ready;
   logic [2:0]  op;
   logic [15:0] input1, input2, answer;
   logic        zerosignal, carry, overflow, negative, busy;

   typedef struct {
      logic [15:0] ans;
      logic        z, c, o, n;
      int          lat;
   } exp_t;

   exp_t sb_q[$];
   int   n_vec = 0;
   int   n_err = 0;

   alu_multicycle #(.WIDTH(16)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .op(op),
      .input1(input1), .input2(input2), .out_valid(out_valid), .out_ready(out_ready),
      .answer(answer), .zerosignal(zerosignal), .carry(carry), .overflow(overflow),
      .negative(negative), .busy(busy)
   );

   always #5 clk = ~clk;

   // lat = clock edges after the accept edge until the edge that registers out_valid.
   function automatic exp_t model(input logic [2:0] o, input logic [15:0] a, input logic [15:0] b);
      exp_t        e;
      int          sa, sb, r;
      logic [16:0] s;
      logic [31:0] p;
      sa = $signed(a);
      sb = $signed(b);
      e.c = 1'b0; e.o = 1'b0; e.lat = 0; e.ans = '0;
      case (o)
         T_ADD: begin
            s = {1'b0, a} + {1'b0, b};
            e.ans = s[15:0]; e.c = s[16];
            r = sa + sb; e.o = (r > 32767) || (r < -32768);
         end
         T_SUB: begin
            e.ans = a - b; e.c = (a >= b);
            r = sa - sb; e.o = (r > 32767) || (r < -32768);
         end
         T_AND: e.ans = a & b;
         T_OR:  e.ans = a | b;
         T_XOR: e.ans = a ^ b;
         T_SLT: e.ans = (sa < sb) ? 16'd1 : 16'd0;
         T_SLL: e.ans = a << b[3:0];
         default: begin
            p = 32'(a) * 32'(b);
            e.ans = p[15:0]; e.o = (p[31:16] != 16'd0); e.lat = 16;
         end
      endcase
      e.z = (e.ans == 16'd0);
      e.n = e.ans[15];
      return e;
   endfunction

   // Waits (bounded) for in_ready, presents one op for one accept edge, queues its expectation.
   task automatic send(input logic [2:0] o, input logic [15:0] a, input logic [15:0] b);
      int t = 0;
      while (!in_ready && t < 100) begin
         @(negedge clk);
         t++;
      end
      if (!in_ready) begin
         n_vec++; n_err++;
         $display("FAIL send_in_ready_timeout: in_ready=%b required 1", in_ready);
      end
      in_valid = 1'b1; op = o; input1 = a; input2 = b;
      sb_q.push_back(model(o, a, b));
      @(posedge clk);
      #1 in_valid = 1'b0;
   endtask

   // Waits (bounded) for out_valid at negedges; reports whether in_ready was seen meanwhile.
   task automatic wait_out(output int lat, output bit rdy_seen);
      lat = 0; rdy_seen = 1'b0;
      @(negedge clk);
      while (!out_valid && lat < 200) begin
         if (in_ready) rdy_seen = 1'b1;
         lat++;
         @(negedge clk);
      end
   endtask

   task automatic drain();
      out_ready = 1'b1;
      @(posedge clk);
      #1 out_ready = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      n_vec++;
      if ({answer, zerosignal, carry, overflow, negative, out_valid, busy, in_ready} !== 23'd0) begin
         n_err++;
         $display("FAIL reset_state: ans=%h z%b c%b o%b n%b ov%b busy%b rdy%b required all 0",
                  answer, zerosignal, carry, overflow, negative, out_valid, busy, in_ready);
      end
      rst = 1'b0;
      @(negedge clk);
      n_vec++;
      if ({in_ready, busy, out_valid} !== 3'b100) begin
         n_err++;
         $display("FAIL reset_release: rdy/busy/ov=%b required 100", {in_ready, busy, out_valid});
      end
   endtask

   task automatic test_add();
      exp_t e; int lat; bit rs;
      send(T_ADD, 16'h7FFF, 16'h0001);
      wait_out(lat, rs);
      e = sb_q.pop_front();
      n_vec++;
      if ({out_valid, answer, zerosignal, carry, overflow, negative} !== {1'b1, e.ans, e.z, e.c, e.o, e.n}) begin
         n_err++;
         $display("FAIL add_result: ov=%b ans=%h zcon=%b%b%b%b required 1 %h %b%b%b%b", out_valid, answer,
                  zerosignal, carry, overflow, negative, e.ans, e.z, e.c, e.o, e.n);
      end
      n_vec++;
      if (lat !== e.lat) begin
         n_err++;
         $display("FAIL add_latency: got %0d required %0d", lat, e.lat);
      end
      drain();
   endtask

   task automatic test_sub();
      exp_t e; int lat; bit rs;
      send(T_SUB, 16'h1234, 16'h1234);
      wait_out(lat, rs);
      e = sb_q.pop_front();
      n_vec++;
      if ({out_valid, answer, zerosignal, carry, overflow, negative} !== {1'b1, e.ans, e.z, e.c, e.o, e.n}) begin
         n_err++;
         $display("FAIL sub_result: ov=%b ans=%h zcon=%b%b%b%b required 1 %h %b%b%b%b", out_valid, answer,
                  zerosignal, carry, overflow, negative, e.ans, e.z, e.c, e.o, e.n);
      end
      drain();
   endtask

   task automatic test_mul();
      logic [15:0] ma[3] = '{16'h0100, 16'hFFFF, 16'h00FF};
      logic [15:0] mb[3] = '{16'h0100, 16'hFFFF, 16'h0003};
      exp_t e; int lat; bit rs;
      for (int i = 0; i < 3; i++) begin
         send(T_MUL, ma[i], mb[i]);
         wait_out(lat, rs);
         e = sb_q.pop_front();
         n_vec++;
         if ({out_valid, answer, zerosignal, carry, overflow, negative} !== {1'b1, e.ans, e.z, e.c, e.o, e.n}) begin
            n_err++;
            $display("FAIL mul_result[%0d]: ov=%b ans=%h zcon=%b%b%b%b required 1 %h %b%b%b%b", i, out_valid,
                     answer, zerosignal, carry, overflow, negative, e.ans, e.z, e.c, e.o, e.n);
         end
         n_vec++;
         if (lat !== e.lat || rs !== 1'b0) begin
            n_err++;
            $display("FAIL mul_timing[%0d]: latency %0d in_ready_seen %b required %0d and 0", i, lat, rs, e.lat);
         end
         drain();
      end
   endtask

   task automatic test_hold();
      exp_t e; int lat; bit rs;
      send(T_ADD, 16'h0005, 16'h0006);
      wait_out(lat, rs);
      e = sb_q.pop_front();
      for (int i = 0; i < 5; i++) begin
         in_valid = (i % 2 == 0); op = T_SUB; input1 = 16'(i); input2 = 16'h0001;
         @(posedge clk);
         @(negedge clk);
         n_vec++;
         if ({out_valid, in_ready, answer, zerosignal, carry, overflow, negative} !==
             {1'b1, 1'b0, e.ans, e.z, e.c, e.o, e.n}) begin
            n_err++;
            $display("FAIL hold_cycle[%0d]: ov=%b rdy=%b ans=%h required 1 0 %h", i, out_valid, in_ready, answer, e.ans);
         end
      end
      in_valid = 1'b0;
      drain();
      n_vec++;
      if ({out_valid, in_ready, busy} !== 3'b010) begin
         n_err++;
         $display("FAIL hold_release: ov/rdy/busy=%b required 010", {out_valid, in_ready, busy});
      end
   endtask

   task automatic test_reset_mid_mul();
      exp_t e; int lat; bit rs;
      send(T_MUL, 16'h1234, 16'h0055);
      repeat (7) @(posedge clk);
      #2 rst = 1'b1;
      #1;
      n_vec++;
      if ({answer, zerosignal, carry, overflow, negative, out_valid, busy, in_ready} !== 23'd0) begin
         n_err++;
         $display("FAIL reset_mid_mul: ans=%h ov=%b busy=%b rdy=%b required all 0", answer, out_valid, busy, in_ready);
      end
      void'(sb_q.pop_back());
      @(negedge clk);
      rst = 1'b0;
      send(T_ADD, 16'h0003, 16'h0004);
      wait_out(lat, rs);
      e = sb_q.pop_front();
      n_vec++;
      if ({out_valid, answer, zerosignal, carry, overflow, negative} !== {1'b1, e.ans, e.z, e.c, e.o, e.n}) begin
         n_err++;
         $display("FAIL add_after_reset: ov=%b ans=%h required 1 %h", out_valid, answer, e.ans);
      end
      drain();
   endtask

   task automatic test_misc();
      logic [2:0]  to[9] = '{T_SLT, T_SLL, T_XOR, T_SLT, T_AND, T_OR, T_SUB, T_SUB, T_ADD};
      logic [15:0] ta[9] = '{16'hFFFF, 16'h0001, 16'hAAAA, 16'h0001, 16'hF0F0, 16'h0F00, 16'h0000, 16'h8000, 16'hFFFF};
      logic [15:0] tb[9] = '{16'h0001, 16'h0013, 16'hFFFF, 16'hFFFF, 16'h3C3C, 16'h00F0, 16'h0001, 16'h0001, 16'h0001};
      exp_t e; int lat; bit rs;
      for (int i = 0; i < 9; i++) begin
         send(to[i], ta[i], tb[i]);
         wait_out(lat, rs);
         e = sb_q.pop_front();
         n_vec++;
         if ({out_valid, answer, zerosignal, carry, overflow, negative} !== {1'b1, e.ans, e.z, e.c, e.o, e.n} ||
             lat !== e.lat) begin
            n_err++;
            $display("FAIL misc[%0d] op%0d: ov=%b ans=%h zcon=%b%b%b%b lat=%0d required 1 %h %b%b%b%b lat=%0d", i,
                     to[i], out_valid, answer, zerosignal, carry, overflow, negative, lat, e.ans, e.z, e.c, e.o,
                     e.n, e.lat);
         end
         drain();
      end
   endtask

   task automatic test_back_to_back();
      exp_t e; int lat; bit rs;
      logic [2:0] o; logic [15:0] a, b;
      for (int i = 0; i < 24; i++) begin
         o = 3'($urandom_range(0, 7));
         a = 16'($urandom);
         b = 16'($urandom);
         send(o, a, b);
         wait_out(lat, rs);
         e = sb_q.pop_front();
         n_vec++;
         if ({out_valid, answer, zerosignal, carry, overflow, negative} !== {1'b1, e.ans, e.z, e.c, e.o, e.n} ||
             lat !== e.lat) begin
            n_err++;
            $display("FAIL rand[%0d] op%0d %h,%h: ans=%h zcon=%b%b%b%b lat=%0d required %h %b%b%b%b lat=%0d", i, o,
                     a, b, answer, zerosignal, carry, overflow, negative, lat, e.ans, e.z, e.c, e.o, e.n, e.lat);
         end
         drain();
      end
   endtask

   initial begin
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; op = '0; input1 = '0; input2 = '0;
      test_reset();
      test_add();
      test_sub();
      test_mul();
      test_hold();
      test_reset_mid_mul();
      test_misc();
      test_back_to_back();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #300000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1);
   end

endmodule
